// File: rtl/l1i_fetch_cache_if.sv
// Fetch-cache bus: line fill port, branch redirect, and the presented-instruction
// handshake toward the parse stage.
interface l1i_fetch_cache_if #(
    parameter int DATA_WIDTH = 60,
    parameter int ADDR_WIDTH = 16
);
    logic                  halt_i;
    logic                  write_enable_i;
    logic [ADDR_WIDTH-1:0] write_address_i;
    logic [DATA_WIDTH-1:0] write_data_i;
    logic                  branch_valid_i;
    logic                  branch_direction_i;
    logic [ADDR_WIDTH-1:0] branch_offset_i;
    logic                  ready_i;
    logic [ADDR_WIDTH-1:0] pc_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  fault_o;

    modport master (
        output halt_i, write_enable_i, write_address_i, write_data_i,
        output branch_valid_i, branch_direction_i, branch_offset_i, ready_i,
        input  pc_o, data_o, valid_o, fault_o
    );

    modport slave (
        input  halt_i, write_enable_i, write_address_i, write_data_i,
        input  branch_valid_i, branch_direction_i, branch_offset_i, ready_i,
        output pc_o, data_o, valid_o, fault_o
    );
endinterface

// File: rtl/l1i_fetch_cache.sv
// Direct-mapped instruction store with a one-cycle fetch pipeline, branch redirect,
// halt/stall handling and a sticky out-of-range fault.
module l1i_fetch_cache #(
    parameter int DATA_WIDTH = 60,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int RESET_PC   = 0
) (
    input logic              clock_i,
    input logic              reset_i,
    l1i_fetch_cache_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L    = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] RESET_PC_A = ADDR_WIDTH'(RESET_PC);

    typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q, pc_o_q, target;
    logic [DATA_WIDTH-1:0] data_q, rd_data;
    logic                  valid_q, fault_q;
    logic                  advance, pc_in_range, wr_en, bypass;
    logic                  do_fetch, do_fault;

    assign advance     = !valid_q || bus.ready_i;
    assign pc_in_range = {1'b0, pc_q} < DEPTH_L;
    assign wr_en       = bus.write_enable_i && ({1'b0, bus.write_address_i} < DEPTH_L);
    assign bypass      = wr_en && (bus.write_address_i == pc_q);
    assign rd_data     = bypass ? bus.write_data_i : mem[pc_q[IDX_W-1:0]];
    assign target      = bus.branch_direction_i ? pc_o_q + bus.branch_offset_i
                                                : pc_o_q - bus.branch_offset_i;

    // Contents are never cleared; the reset branch only suppresses writes while reset is held.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
        end else if (wr_en) begin
            mem[bus.write_address_i[IDX_W-1:0]] <= bus.write_data_i;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) state_q <= RUN;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.branch_valid_i) begin
            state_d = bus.halt_i ? HALTED : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.halt_i)                     state_d = HALTED;
                    else if (advance && !pc_in_range)   state_d = FAULT;
                end
                HALTED:  if (!bus.halt_i) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        do_fetch = 1'b0;
        do_fault = 1'b0;
        if (!bus.branch_valid_i && state_q == RUN && !bus.halt_i && advance) begin
            do_fetch = pc_in_range;
            do_fault = !pc_in_range;
        end
    end

    // A redirect squashes whatever is presented, so it wins even over a stall.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            pc_q    <= RESET_PC_A;
            pc_o_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (bus.branch_valid_i) begin
            pc_q    <= target;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (do_fetch) begin
            pc_o_q  <= pc_q;
            data_q  <= rd_data;
            valid_q <= 1'b1;
            pc_q    <= pc_q + 1'b1;
        end else if (advance) begin
            valid_q <= 1'b0;
            if (do_fault) fault_q <= 1'b1;
        end
    end

    assign bus.pc_o    = pc_o_q;
    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
    assign bus.fault_o = fault_q;
endmodule

// File: tb/tb_l1i_fetch_cache.sv
// Randomized and directed checks of l1i_fetch_cache against a cycle-level reference model.
module tb_l1i_fetch_cache;
    localparam int DW = 60;
    localparam int AW = 16;
    localparam int DEPTH = 256;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;
    int total = 0;
    int bad = 0;

    l1i_fetch_cache_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    l1i_fetch_cache #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .bus    (bus)
    );

    always #5 clock_i = ~clock_i;

    // Reference model: expected outputs plus fetch pointer and mode (0 run, 1 halted, 2 fault).
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    logic [AW-1:0] m_pc, e_pc;
    logic [DW-1:0] e_data;
    bit            e_valid, e_fault, e_dknown;
    int            m_mode;

    task automatic m_reset();
        m_pc = '0; m_mode = 0;
        e_pc = '0; e_data = '0; e_dknown = 1; e_valid = 0; e_fault = 0;
    endtask

    task automatic model_step();
        bit adv, wr;
        int wa;
        if (!reset_i) begin
            m_reset();
            return;
        end
        adv = !e_valid || bus.ready_i;
        wa  = int'(bus.write_address_i);
        wr  = bus.write_enable_i && wa < DEPTH;
        if (bus.branch_valid_i) begin
            m_pc    = bus.branch_direction_i ? e_pc + bus.branch_offset_i : e_pc - bus.branch_offset_i;
            e_valid = 0;
            e_fault = 0;
            m_mode  = bus.halt_i ? 1 : 0;
        end else if (m_mode == 0) begin
            if (bus.halt_i) begin
                m_mode = 1;
                if (adv) e_valid = 0;
            end else if (adv) begin
                if (int'(m_pc) < DEPTH) begin
                    e_pc = m_pc;
                    e_valid = 1;
                    if (wr && wa == int'(m_pc)) begin
                        e_data = bus.write_data_i; e_dknown = 1;
                    end else begin
                        e_data = m_mem[m_pc]; e_dknown = m_known[m_pc];
                    end
                    m_pc = m_pc + 1'b1;
                end else begin
                    e_valid = 0; e_fault = 1; m_mode = 2;
                end
            end
        end else if (m_mode == 1) begin
            if (adv) e_valid = 0;
            if (!bus.halt_i) m_mode = 0;
        end
        if (wr) begin
            m_mem[wa] = bus.write_data_i;
            m_known[wa] = 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.halt_i = 0; bus.write_enable_i = 0; bus.write_address_i = '0; bus.write_data_i = '0;
        bus.branch_valid_i = 0; bus.branch_direction_i = 0; bus.branch_offset_i = '0; bus.ready_i = 1;
    endtask

    task automatic wr_line(input int a, input logic [DW-1:0] d);
        bus.write_enable_i = 1; bus.write_address_i = AW'(a); bus.write_data_i = d;
        tick();
        bus.write_enable_i = 0;
    endtask

    task automatic branch(input bit dir, input int off);
        bus.branch_valid_i = 1; bus.branch_direction_i = dir; bus.branch_offset_i = AW'(off);
        tick();
        bus.branch_valid_i = 0;
    endtask

    task automatic pulse_reset();
        reset_i = 0; m_reset();
        #2 reset_i = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.halt_i = 1;
        #2 reset_i = 0;
        m_reset();
        #2;
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", bus.valid_o); end
        total++; if (bus.pc_o !== '0) begin bad++; $display("FAIL reset_pc: got %0h want 0", bus.pc_o); end
        total++; if (bus.data_o !== '0) begin bad++; $display("FAIL reset_data: got %0h want 0", bus.data_o); end
        total++; if (bus.fault_o !== 1'b0) begin bad++; $display("FAIL reset_fault: got %0b want 0", bus.fault_o); end
        @(posedge clock_i); #1;
        reset_i = 1;
        tick();
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL halted_after_reset: got valid %0b want 0", bus.valid_o); end
        for (int i = 0; i < 16; i++) wr_line(i, DW'(8'hA0 + i));
        wr_line(254, DW'(8'hFE));
        wr_line(255, DW'(8'hFF));
        wr_line(300, DW'(12'hBEE));
        bus.halt_i = 0;
    endtask

    task automatic test_sequential();
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (bus.pc_o !== AW'(i) || bus.data_o !== DW'(8'hA0 + i) || bus.valid_o !== 1'b1) begin
                bad++; $display("FAIL seq_fetch%0d: got pc=%0h data=%0h v=%0b want pc=%0h data=%0h v=1",
                                i, bus.pc_o, bus.data_o, bus.valid_o, i, 8'hA0 + i);
            end
        end
    endtask

    task automatic test_stall();
        pulse_reset();
        for (int i = 0; i < 3; i++) tick();
        bus.ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.pc_o !== AW'(2) || bus.data_o !== DW'(8'hA2) || bus.valid_o !== 1'b1) begin
                bad++; $display("FAIL stall_hold%0d: got pc=%0h data=%0h v=%0b want pc=2 data=a2 v=1",
                                i, bus.pc_o, bus.data_o, bus.valid_o);
            end
        end
        bus.ready_i = 1;
        tick();
        total++;
        if (bus.pc_o !== AW'(3) || bus.data_o !== DW'(8'hA3) || bus.valid_o !== 1'b1) begin
            bad++; $display("FAIL stall_release: got pc=%0h data=%0h v=%0b want pc=3 data=a3 v=1",
                            bus.pc_o, bus.data_o, bus.valid_o);
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 40 && !(e_valid && e_pc == 10); i++) tick();
        total++; if (bus.pc_o !== AW'(10)) begin bad++; $display("FAIL br_setup: got pc=%0h want a", bus.pc_o); end
        branch(0, 7);
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL br_back_squash: got v=%0b want 0", bus.valid_o); end
        tick();
        total++;
        if (bus.pc_o !== AW'(3) || bus.data_o !== DW'(8'hA3) || bus.valid_o !== 1'b1) begin
            bad++; $display("FAIL br_back_target: got pc=%0h data=%0h v=%0b want pc=3 data=a3 v=1",
                            bus.pc_o, bus.data_o, bus.valid_o);
        end
        for (int i = 0; i < 40 && !(e_valid && e_pc == 10); i++) tick();
        branch(1, 16'hFFFF);
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL br_wrap_squash: got v=%0b want 0", bus.valid_o); end
        tick();
        total++;
        if (bus.pc_o !== AW'(9) || bus.data_o !== DW'(8'hA9) || bus.valid_o !== 1'b1) begin
            bad++; $display("FAIL br_wrap_target: got pc=%0h data=%0h v=%0b want pc=9 data=a9 v=1",
                            bus.pc_o, bus.data_o, bus.valid_o);
        end
    endtask

    task automatic test_fault();
        branch(1, 254 - 9);
        tick();
        total++;
        if (bus.pc_o !== AW'(254) || bus.data_o !== DW'(8'hFE) || bus.valid_o !== 1'b1) begin
            bad++; $display("FAIL fault_line254: got pc=%0h data=%0h v=%0b want pc=fe data=fe v=1",
                            bus.pc_o, bus.data_o, bus.valid_o);
        end
        tick();
        total++;
        if (bus.pc_o !== AW'(255) || bus.data_o !== DW'(8'hFF) || bus.valid_o !== 1'b1) begin
            bad++; $display("FAIL fault_line255: got pc=%0h data=%0h v=%0b want pc=ff data=ff v=1",
                            bus.pc_o, bus.data_o, bus.valid_o);
        end
        tick();
        total++;
        if (bus.valid_o !== 1'b0 || bus.fault_o !== 1'b1) begin
            bad++; $display("FAIL fault_raise: got v=%0b f=%0b want v=0 f=1", bus.valid_o, bus.fault_o);
        end
        bus.halt_i = 1;
        tick(); tick();
        bus.halt_i = 0;
        tick();
        total++;
        if (bus.valid_o !== 1'b0 || bus.fault_o !== 1'b1) begin
            bad++; $display("FAIL fault_sticky: got v=%0b f=%0b want v=0 f=1", bus.valid_o, bus.fault_o);
        end
        branch(0, 255);
        total++;
        if (bus.valid_o !== 1'b0 || bus.fault_o !== 1'b0) begin
            bad++; $display("FAIL fault_clear: got v=%0b f=%0b want v=0 f=0", bus.valid_o, bus.fault_o);
        end
        tick();
        total++;
        if (bus.pc_o !== AW'(0) || bus.data_o !== DW'(8'hA0) || bus.valid_o !== 1'b1) begin
            bad++; $display("FAIL fault_recover: got pc=%0h data=%0h v=%0b want pc=0 data=a0 v=1",
                            bus.pc_o, bus.data_o, bus.valid_o);
        end
    endtask

    task automatic test_bypass();
        for (int i = 0; i < 40 && !(e_valid && e_pc == 6); i++) tick();
        wr_line(7, DW'(8'h5A));
        total++;
        if (bus.pc_o !== AW'(7) || bus.data_o !== DW'(8'h5A) || bus.valid_o !== 1'b1) begin
            bad++; $display("FAIL bypass: got pc=%0h data=%0h v=%0b want pc=7 data=5a v=1",
                            bus.pc_o, bus.data_o, bus.valid_o);
        end
        branch(0, 0);
        tick();
        total++;
        if (bus.pc_o !== AW'(7) || bus.data_o !== DW'(8'h5A)) begin
            bad++; $display("FAIL bypass_stored: got pc=%0h data=%0h want pc=7 data=5a", bus.pc_o, bus.data_o);
        end
    endtask

    task automatic test_halt_reset();
        branch(0, 3);
        tick();
        total++; if (bus.pc_o !== AW'(4) || bus.valid_o !== 1'b1) begin bad++; $display("FAIL halt_setup: got pc=%0h v=%0b want pc=4 v=1", bus.pc_o, bus.valid_o); end
        bus.halt_i = 1;
        tick();
        total++; if (bus.valid_o !== 1'b0 || bus.pc_o !== AW'(4)) begin bad++; $display("FAIL halt_drop: got pc=%0h v=%0b want pc=4 v=0", bus.pc_o, bus.valid_o); end
        tick(); tick();
        total++; if (bus.valid_o !== 1'b0 || bus.pc_o !== AW'(4)) begin bad++; $display("FAIL halt_hold: got pc=%0h v=%0b want pc=4 v=0", bus.pc_o, bus.valid_o); end
        bus.halt_i = 0;
        tick();
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL unhalt_gap: got v=%0b want 0", bus.valid_o); end
        tick();
        total++;
        if (bus.pc_o !== AW'(5) || bus.data_o !== DW'(8'hA5) || bus.valid_o !== 1'b1) begin
            bad++; $display("FAIL unhalt_resume: got pc=%0h data=%0h v=%0b want pc=5 data=a5 v=1",
                            bus.pc_o, bus.data_o, bus.valid_o);
        end
        tick(); tick();
        reset_i = 0; m_reset();
        #1;
        total++;
        if (bus.valid_o !== 1'b0 || bus.pc_o !== '0 || bus.data_o !== '0 || bus.fault_o !== 1'b0) begin
            bad++; $display("FAIL async_reset: got pc=%0h data=%0h v=%0b f=%0b want all 0",
                            bus.pc_o, bus.data_o, bus.valid_o, bus.fault_o);
        end
        bus.write_enable_i = 1; bus.write_address_i = AW'(5); bus.write_data_i = DW'(12'hBAD);
        @(posedge clock_i); #1;
        bus.write_enable_i = 0;
        reset_i = 1;
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (bus.pc_o !== AW'(5) || bus.data_o !== DW'(8'hA5)) begin
            bad++; $display("FAIL reset_blocks_write: got pc=%0h data=%0h want pc=5 data=a5", bus.pc_o, bus.data_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            bus.ready_i            = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) == 0) bus.halt_i = ~bus.halt_i;
            bus.branch_valid_i     = ($urandom_range(0, 11) == 0);
            bus.branch_direction_i = $urandom_range(0, 1) != 0;
            bus.branch_offset_i    = AW'($urandom_range(0, 300));
            bus.write_enable_i     = $urandom_range(0, 1) != 0;
            bus.write_address_i    = AW'($urandom_range(0, 299));
            bus.write_data_i       = DW'({$urandom(), $urandom()});
            if ($urandom_range(0, 299) == 0) begin
                reset_i = 0; m_reset();
                #1;
                total++;
                if (bus.valid_o !== 1'b0 || bus.pc_o !== '0 || bus.fault_o !== 1'b0) begin
                    bad++; $display("FAIL rnd_reset cyc=%0d: got pc=%0h v=%0b f=%0b want 0", i, bus.pc_o, bus.valid_o, bus.fault_o);
                end
                tick();
                reset_i = 1;
            end
            tick();
            total++; if (bus.valid_o !== e_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d: got %0b want %0b", i, bus.valid_o, e_valid); end
            total++; if (bus.pc_o !== e_pc) begin bad++; $display("FAIL rnd_pc cyc=%0d: got %0h want %0h", i, bus.pc_o, e_pc); end
            total++; if (bus.fault_o !== e_fault) begin bad++; $display("FAIL rnd_fault cyc=%0d: got %0b want %0b", i, bus.fault_o, e_fault); end
            if (e_dknown) begin
                total++; if (bus.data_o !== e_data) begin bad++; $display("FAIL rnd_data cyc=%0d: got %0h want %0h", i, bus.data_o, e_data); end
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_fault();
        test_bypass();
        test_halt_reset();
        idle_inputs();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
